// File: rtl/mcdf_pkg.sv
// Shared types and helpers for the MCDF packet formatter: FSM state encoding,
// field widths and the packet-length select decode.
package mcdf_pkg;

  localparam int CHID_W = 2;
  localparam int LEN_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    IDREQ,
    ACK,
    RECV,
    REQ,
    SEND
  } fmt_state_e;

  // Select values 3..7 all map to the largest packet size.
  function automatic logic [LEN_W-1:0] pkglen_decode(input logic [2:0] sel);
    case (sel)
      3'd0:    return LEN_W'(4);
      3'd1:    return LEN_W'(8);
      3'd2:    return LEN_W'(16);
      default: return LEN_W'(32);
    endcase
  endfunction

endpackage

// File: rtl/mcdf_formatter_if.sv
// Arbiter-side and downstream-link signals of the formatter, grouped as one bundle.
// master = formatter side, slave = arbiter/link (or testbench) side.
interface mcdf_formatter_if #(
  parameter int DW = 32
) ();
  import mcdf_pkg::*;

  logic              f2a_id_req_o;
  logic              f2a_ack_o;
  logic              a2f_val_i;
  logic [CHID_W-1:0] a2f_id_i;
  logic [DW-1:0]     a2f_data_i;
  logic [2:0]        a2f_pkglen_sel_i;
  logic              fmt_req_o;
  logic              fmt_grant_i;
  logic [CHID_W-1:0] fmt_chid_o;
  logic [LEN_W-1:0]  fmt_length_o;
  logic [DW-1:0]     fmt_data_o;
  logic              fmt_start_o;
  logic              fmt_end_o;
  logic              err_timeout_o;

  modport master (
    output f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o,
           fmt_data_o, fmt_start_o, fmt_end_o, err_timeout_o,
    input  a2f_val_i, a2f_id_i, a2f_data_i, a2f_pkglen_sel_i, fmt_grant_i
  );

  modport slave (
    input  f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o,
           fmt_data_o, fmt_start_o, fmt_end_o, err_timeout_o,
    output a2f_val_i, a2f_id_i, a2f_data_i, a2f_pkglen_sel_i, fmt_grant_i
  );

endinterface

// File: rtl/mcdf_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; rdata always shows the
// oldest stored word, so a pop consumes the word visible in the same cycle.
module mcdf_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; pointers and count alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mcdf_formatter.sv
// MCDF packet formatter: id handshake with the arbiter, store-and-forward buffering,
// framed burst to the link. Define MCDF_FMT_PARITY_EN to append an XOR parity word.
module mcdf_formatter
  import mcdf_pkg::*;
#(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int RX_TIMEOUT = 64
) (
  input logic              clk_i,
  input logic              rstn_i,
  mcdf_formatter_if.master bus
);

  localparam int IDLE_W = $clog2(RX_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RX_TIMEOUT - 1);

  fmt_state_e        state;
  fmt_state_e        state_nxt;
  logic [CHID_W-1:0] chid_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  out_len;
  logic [LEN_W-1:0]  rx_cnt;
  logic [LEN_W-1:0]  tx_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              beat;
  logic              last_beat;
  logic              timeout;
  logic              last_word;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DW-1:0]     fifo_wdata;
  logic [DW-1:0]     fifo_rdata;

  assign beat      = (state == RECV) && bus.a2f_val_i;
  assign last_beat = beat && (rx_cnt == len_r - LEN_W'(1));
  // Fires on the RX_TIMEOUT-th consecutive idle cycle of RECV.
  assign timeout   = (state == RECV) && !bus.a2f_val_i && (idle_cnt == IDLE_LAST);
  assign last_word = (state == SEND) && (tx_cnt == out_len - LEN_W'(1));
  assign fifo_pop  = (state == SEND) && !fifo_empty;

`ifdef MCDF_FMT_PARITY_EN
  logic [DW-1:0]    parity_r;
  logic             parity_done;
  logic             parity_push;
  logic [LEN_W-1:0] len_out_r;

  // The parity word is queued in the first REQ cycle, after the last data word.
  assign parity_push = (state == REQ) && !parity_done;
  assign fifo_push   = (beat || parity_push) && !fifo_full;
  assign fifo_wdata  = parity_push ? parity_r : bus.a2f_data_i;
  assign out_len     = len_out_r;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      parity_r    <= '0;
      parity_done <= 1'b0;
      len_out_r   <= '0;
    end else if (state == ACK) begin
      parity_r    <= '0;
      parity_done <= 1'b0;
      len_out_r   <= pkglen_decode(bus.a2f_pkglen_sel_i) + LEN_W'(1);
    end else begin
      if (beat)        parity_r    <= parity_r ^ bus.a2f_data_i;
      if (parity_push) parity_done <= 1'b1;
    end
  end
`else
  assign fifo_push  = beat && !fifo_full;
  assign fifo_wdata = bus.a2f_data_i;
  assign out_len    = len_r;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: state_nxt takes its default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = IDREQ;
      IDREQ: state_nxt = ACK;
      ACK:   state_nxt = RECV;
      RECV: begin
        if (timeout)        state_nxt = IDLE;
        else if (last_beat) state_nxt = REQ;
      end
      REQ:   if (bus.fmt_grant_i) state_nxt = SEND;
      SEND:  if (last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      chid_r   <= '0;
      len_r    <= '0;
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      idle_cnt <= '0;
    end else begin
      if (state == ACK) begin
        chid_r <= bus.a2f_id_i;
        len_r  <= pkglen_decode(bus.a2f_pkglen_sel_i);
        rx_cnt <= '0;
      end else if (beat) begin
        rx_cnt <= rx_cnt + LEN_W'(1);
      end
      idle_cnt <= (state != RECV || beat) ? '0 : idle_cnt + IDLE_W'(1);
      tx_cnt   <= (state == SEND) ? tx_cnt + LEN_W'(1) : '0;
    end
  end

  mcdf_sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .flush  (timeout),
    .wdata  (fifo_wdata),
    .rdata  (fifo_rdata),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign bus.f2a_id_req_o  = (state == IDREQ);
  assign bus.f2a_ack_o     = (state == ACK);
  assign bus.fmt_req_o     = (state == REQ);
  assign bus.fmt_chid_o    = chid_r;
  assign bus.fmt_length_o  = out_len;
  assign bus.fmt_data_o    = (state == SEND) ? fifo_rdata : '0;
  assign bus.fmt_start_o   = (state == SEND) && (tx_cnt == '0);
  assign bus.fmt_end_o     = last_word;
  assign bus.err_timeout_o = timeout;

endmodule
